// File: rtl/deskew_ctrl_if.sv
// deskew_ctrl_if: one single-port BRAM access bus, instanced three times
// around deskew_ctrl (host side, engine side, memory side).
//
// Parameters:
//   WIDTH  - data width
//   ADDR_W - byte address width
// Signals:
//   en     - access enable (one access per cycle where en=1)
//   we     - byte write enables, meaningful only with en=1
//   addr   - byte address
//   wdata  - write data
//   rdata  - read data
//
// Handshake: there is no ready/backpressure. The master owns en/we/addr/wdata
// and an access is taken in every cycle where en=1; for a read, rdata carries
// the addressed word in the following cycle (one-cycle BRAM latency). The
// slave always drives rdata; a slave that is not granted the port drives 0.
interface deskew_ctrl_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 13
);
    logic              en;
    logic [3:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  rdata;

    modport master (output en, we, addr, wdata, input rdata);
    modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/deskew_ctrl.sv
// deskew_ctrl: sequencer and BRAM port owner for the Deskew engine.
// The host loads the image through the host port, requests a pass with
// host_start, and the controller hands the single BRAM port to the engine
// until eng_done; it then returns the port and pulses done_irq.
//
// Optional feature: define DESKEW_CTRL_WATCHDOG_EN to add a watchdog that
// aborts a pass after TIMEOUT RUN cycles (ABORT state, status[2]).
//
// Ports:
//   clk, reset     - clock, synchronous active-low reset
//   host_start     - pass request (level, sampled in IDLE)
//   host           - host BRAM bus (slave side)
//   busy           - pass in progress, host accesses are dropped
//   done_irq       - one-cycle pulse at end (or abort) of a pass
//   status         - [0] last pass ok, [1] collision, [2] timeout, [3] 0
//   frame_cnt      - completed passes, wraps
//   eng_reset      - engine reset, active-low
//   eng_start      - one-cycle engine start
//   eng_ready      - engine idle
//   eng_done       - engine finished
//   eng            - engine BRAM bus (slave side)
//   mem            - BRAM bus (master side)
//   state_dbg      - current FSM state encoding
module deskew_ctrl
`ifdef DESKEW_CTRL_WATCHDOG_EN
#(
    parameter int TIMEOUT = 20000
)
`endif
(
    input  logic                clk,
    input  logic                reset,
    input  logic                host_start,
    deskew_ctrl_if.slave        host,
    output logic                busy,
    output logic                done_irq,
    output logic [3:0]          status,
    output logic [7:0]          frame_cnt,
    output logic                eng_reset,
    output logic                eng_start,
    input  logic                eng_ready,
    input  logic                eng_done,
    deskew_ctrl_if.slave        eng,
    deskew_ctrl_if.master       mem,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        DONE   = 3'd3
`ifdef DESKEW_CTRL_WATCHDOG_EN
        , ABORT = 3'd4
`endif
    } state_t;

    state_t state;
    logic   owner_eng;   // 0: host owns the BRAM port, 1: engine owns it
    logic   pass_ok;
    logic   collision;
    logic   abort_pulse;
    logic   timeout_flag;

`ifdef DESKEW_CTRL_WATCHDOG_EN
    logic [31:0] wd_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            owner_eng   <= 1'b0;
            busy        <= 1'b0;
            done_irq    <= 1'b0;
            eng_start   <= 1'b0;
            pass_ok     <= 1'b0;
            collision   <= 1'b0;
            frame_cnt   <= 8'd0;
            abort_pulse <= 1'b0;
`ifdef DESKEW_CTRL_WATCHDOG_EN
            timeout_flag <= 1'b0;
            wd_cnt       <= '0;
`endif
        end else begin
            eng_start   <= 1'b0;
            done_irq    <= 1'b0;
            abort_pulse <= 1'b0;

            // busy is never set in IDLE, so this cannot race the start clear.
            if (busy && host.en) begin
                collision <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (host_start && eng_ready) begin
                        state     <= LAUNCH;
                        eng_start <= 1'b1;
                        busy      <= 1'b1;
                        pass_ok   <= 1'b0;
                        collision <= 1'b0;
                    end
                end
                LAUNCH: begin
                    owner_eng <= 1'b1;
                    state     <= RUN;
`ifdef DESKEW_CTRL_WATCHDOG_EN
                    wd_cnt    <= '0;
`endif
                end
                RUN: begin
                    if (eng_done) begin
                        state     <= DONE;
                        done_irq  <= 1'b1;
                        pass_ok   <= 1'b1;
                        frame_cnt <= frame_cnt + 8'd1;
                    end
`ifdef DESKEW_CTRL_WATCHDOG_EN
                    // wd_cnt counts RUN cycles already spent; abort when this
                    // cycle makes the count reach TIMEOUT.
                    else if (wd_cnt == 32'(TIMEOUT - 1)) begin
                        state        <= ABORT;
                        done_irq     <= 1'b1;
                        abort_pulse  <= 1'b1;
                        pass_ok      <= 1'b0;
                        timeout_flag <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
`endif
                end
                DONE: begin
                    owner_eng <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
`ifdef DESKEW_CTRL_WATCHDOG_EN
                ABORT: begin
                    owner_eng <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef DESKEW_CTRL_WATCHDOG_EN
    assign timeout_flag = 1'b0;
`endif

    assign status    = {1'b0, timeout_flag, collision, pass_ok};
    assign eng_reset = reset & ~abort_pulse;
    assign state_dbg = state;

    // Port mux on the registered owner bit. While busy the host keeps
    // addr/wdata visible but its en/we never reach the BRAM.
    assign mem.addr   = owner_eng ? eng.addr  : host.addr;
    assign mem.wdata  = owner_eng ? eng.wdata : host.wdata;
    assign mem.en     = owner_eng ? eng.en    : (host.en & ~busy);
    assign mem.we     = owner_eng ? eng.we    : (busy ? 4'h0 : host.we);
    assign host.rdata = owner_eng ? '0        : mem.rdata;
    assign eng.rdata  = owner_eng ? mem.rdata : '0;

endmodule

// File: tb/tb_deskew_ctrl.sv
// tb_deskew_ctrl: directed bench for deskew_ctrl with a behavioural
// one-cycle-latency BRAM and a scripted engine.
module tb_deskew_ctrl;

    localparam int WIDTH  = 16;
    localparam int ADDR_W = 13;
    localparam int N_PIX  = 784;
    localparam int N_ENG  = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic       host_start;
    logic       eng_ready;
    logic       eng_done;
    logic       busy;
    logic       done_irq;
    logic [3:0] status;
    logic [7:0] frame_cnt;
    logic       eng_reset;
    logic       eng_start;
    logic [2:0] state_dbg;

    deskew_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) host_if ();
    deskew_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) eng_if ();
    deskew_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) mem_if ();

    logic [WIDTH-1:0] ram [0:(1<<(ADDR_W-2))-1];
    logic [WIDTH-1:0] exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / DUT ----------------
    always #5 clk = ~clk;

`ifdef DESKEW_CTRL_WATCHDOG_EN
    deskew_ctrl #(.TIMEOUT(100)) dut (
`else
    deskew_ctrl dut (
`endif
        .clk        (clk),
        .reset      (reset),
        .host_start (host_start),
        .host       (host_if),
        .busy       (busy),
        .done_irq   (done_irq),
        .status     (status),
        .frame_cnt  (frame_cnt),
        .eng_reset  (eng_reset),
        .eng_start  (eng_start),
        .eng_ready  (eng_ready),
        .eng_done   (eng_done),
        .eng        (eng_if),
        .mem        (mem_if),
        .state_dbg  (state_dbg)
    );

    // Behavioural BRAM: word-addressed by addr[ADDR_W-1:2], byte lanes 0/1.
    always @(posedge clk) begin
        if (mem_if.en) begin
            if (mem_if.we[0]) ram[mem_if.addr[ADDR_W-1:2]][7:0]  <= mem_if.wdata[7:0];
            if (mem_if.we[1]) ram[mem_if.addr[ADDR_W-1:2]][15:8] <= mem_if.wdata[15:8];
            mem_if.rdata <= ram[mem_if.addr[ADDR_W-1:2]];
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [WIDTH-1:0] pix(input int i);
        return WIDTH'(i * 37 + 256);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input int addr, input logic [WIDTH-1:0] data);
        host_if.en    = 1'b1;
        host_if.we    = 4'h3;
        host_if.addr  = ADDR_W'(addr);
        host_if.wdata = data;
        tick();
        host_if.en    = 1'b0;
        host_if.we    = 4'h0;
    endtask

    // Reads one word and scores it against the head of exp_q.
    task automatic host_read(input string tag, input int addr);
        logic [WIDTH-1:0] e;
        host_if.en   = 1'b1;
        host_if.we   = 4'h0;
        host_if.addr = ADDR_W'(addr);
        tick();
        host_if.en   = 1'b0;
        e = exp_q.pop_front();
        check(tag, 32'(host_if.rdata), 32'(e));
    endtask

    task automatic run_pass();
        host_start = 1'b1;
        eng_ready  = 1'b1;
        tick();
        host_start = 1'b0;
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        reset         = 1'b0;
        host_start    = 1'b0;
        eng_ready     = 1'b0;
        eng_done      = 1'b0;
        host_if.en    = 1'b0;
        host_if.we    = 4'h0;
        host_if.addr  = '0;
        host_if.wdata = '0;
        eng_if.en     = 1'b0;
        eng_if.we     = 4'h0;
        eng_if.addr   = '0;
        eng_if.wdata  = '0;

        // Reset state and host pass-through during reset.
        tick(); tick();
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done_irq",  32'(done_irq),  32'd0);
        check("rst_eng_start", 32'(eng_start), 32'd0);
        check("rst_eng_reset", 32'(eng_reset), 32'd0);
        check("rst_status",    32'(status),    32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_state",     32'(state_dbg), 32'(S_IDLE));
        host_if.addr  = 13'h123;
        host_if.wdata = 16'h5A5A;
        host_if.en    = 1'b1;
        host_if.we    = 4'h3;
        eng_if.addr   = 13'h0F0;
        eng_if.en     = 1'b1;
        #1;
        check("rst_mem_addr",  32'(mem_if.addr),  32'h123);
        check("rst_mem_din",   32'(mem_if.wdata), 32'h5A5A);
        check("rst_mem_en",    32'(mem_if.en),    32'd1);
        check("rst_mem_we",    32'(mem_if.we),    32'h3);
        tick();
        host_if.en = 1'b0;
        host_if.we = 4'h0;
        eng_if.en  = 1'b0;
        reset = 1'b1;
        tick();
        check("post_rst_eng_reset", 32'(eng_reset), 32'd1);

        // Load the image, run one pass, read back.
        for (int i = 0; i < N_PIX; i++) host_write(i * 4, pix(i));
        eng_ready  = 1'b1;
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        check("p1_eng_start_hi", 32'(eng_start), 32'd1);
        check("p1_busy_launch",  32'(busy),      32'd1);
        check("p1_state_launch", 32'(state_dbg), 32'(S_LAUNCH));
        tick();
        check("p1_eng_start_lo", 32'(eng_start), 32'd0);
        check("p1_state_run",    32'(state_dbg), 32'(S_RUN));
        for (int k = 0; k < N_ENG; k++) begin
            eng_if.en    = 1'b1;
            eng_if.we    = 4'h3;
            eng_if.addr  = ADDR_W'((N_PIX + k) * 4);
            eng_if.wdata = 16'hA000 + 16'(k);
            tick();
        end
        eng_if.we   = 4'h0;
        eng_if.addr = ADDR_W'(5 * 4);
        tick();
        eng_if.en = 1'b0;
        check("p1_eng_rdata",  32'(eng_if.rdata),  32'(pix(5)));
        check("p1_host_rdata", 32'(host_if.rdata), 32'd0);
        check("p1_busy_run",   32'(busy),          32'd1);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("p1_done_irq",  32'(done_irq),  32'd1);
        check("p1_busy_done", 32'(busy),      32'd1);
        check("p1_status",    32'(status),    32'b0001);
        check("p1_frame_cnt", 32'(frame_cnt), 32'd1);
        tick();
        check("p1_done_irq_lo", 32'(done_irq),  32'd0);
        check("p1_busy_lo",     32'(busy),      32'd0);
        check("p1_state_idle",  32'(state_dbg), 32'(S_IDLE));
        for (int i = 0; i < N_PIX; i++) begin
            exp_q.push_back(pix(i));
            host_read("p1_img_rd", i * 4);
        end
        for (int k = 0; k < N_ENG; k++) begin
            exp_q.push_back(16'hA000 + 16'(k));
            host_read("p1_eng_rd", (N_PIX + k) * 4);
        end

        // Port isolation: host write during RUN is dropped.
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        tick();
        host_if.en    = 1'b1;
        host_if.we    = 4'hF;
        host_if.addr  = '0;
        host_if.wdata = 16'hBEEF;
        #1;
        check("iso_mem_en", 32'(mem_if.en), 32'd0);
        check("iso_mem_we", 32'(mem_if.we), 32'd0);
        tick();
        host_if.en = 1'b0;
        host_if.we = 4'h0;
        check("iso_status_coll", 32'(status),        32'b0010);
        check("iso_host_rdata",  32'(host_if.rdata), 32'd0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("iso_status_done", 32'(status),    32'b0011);
        check("iso_frame_cnt",   32'(frame_cnt), 32'd2);
        tick();
        exp_q.push_back(pix(0));
        host_read("iso_word0", 0);

        // Start gating and back-to-back passes with host_start held high.
        eng_ready  = 1'b0;
        host_start = 1'b1;
        tick();
        check("gate_no_start", 32'(eng_start), 32'd0);
        check("gate_no_busy",  32'(busy),      32'd0);
        check("gate_idle",     32'(state_dbg), 32'(S_IDLE));
        eng_ready = 1'b1;
        tick();
        check("b2b_start1",     32'(eng_start), 32'd1);
        check("b2b_coll_clear", 32'(status),    32'b0000);
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("b2b_done_irq", 32'(done_irq),  32'd1);
        check("b2b_state",    32'(state_dbg), 32'(S_DONE));
        check("b2b_eng_st_d", 32'(eng_start), 32'd0);
        tick();
        check("b2b_idle_busy", 32'(busy),      32'd0);
        check("b2b_idle_st",   32'(eng_start), 32'd0);
        check("b2b_idle",      32'(state_dbg), 32'(S_IDLE));
        tick();
        host_start = 1'b0;
        check("b2b_start2", 32'(eng_start), 32'd1);
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        tick();
        check("b2b_frame_cnt", 32'(frame_cnt), 32'd4);

`ifdef DESKEW_CTRL_WATCHDOG_EN
        // Watchdog: engine never finishes.
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        tick();
        n = 0;
        while (!done_irq && n < 300) begin
            tick();
            n++;
        end
        check("wd_run_cycles", 32'(n),         32'd100);
        check("wd_eng_reset",  32'(eng_reset), 32'd0);
        check("wd_status",     32'(status),    32'b0100);
        check("wd_frame_cnt",  32'(frame_cnt), 32'd4);
        tick();
        check("wd_busy",        32'(busy),      32'd0);
        check("wd_eng_reset_h", 32'(eng_reset), 32'd1);
        check("wd_irq_lo",      32'(done_irq),  32'd0);
`endif

        // Reset mid-pass.
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        tick();
        check("mr_state_run", 32'(state_dbg), 32'(S_RUN));
        reset = 1'b0;
        tick();
        check("mr_state",     32'(state_dbg), 32'(S_IDLE));
        check("mr_busy",      32'(busy),      32'd0);
        check("mr_status",    32'(status),    32'd0);
        check("mr_frame_cnt", 32'(frame_cnt), 32'd0);
        check("mr_eng_reset", 32'(eng_reset), 32'd0);
        check("mr_irq",       32'(done_irq),  32'd0);
        reset = 1'b1;
        tick();
        check("mr_irq_after", 32'(done_irq),  32'd0);
        check("mr_eng_rst_h", 32'(eng_reset), 32'd1);

        // Frame counter wrap.
        for (int p = 0; p < 255; p++) run_pass();
        check("wrap_255", 32'(frame_cnt), 32'd255);
        run_pass();
        check("wrap_0", 32'(frame_cnt), 32'd0);
        check("wrap_status", 32'(status), 32'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/deskew_ctrl.md
# deskew_ctrl

Sequencer and memory-port owner for the Deskew engine. Sits between the host-side register/BRAM interface and the engine. It lets the host load a 28x28 image into the shared image BRAM, launches a deskew pass on a host start pulse, and hands the single BRAM port to the engine for the whole pass. When the pass ends it returns the port to the host and raises a one-cycle completion interrupt. An optional watchdog aborts and resets a hung engine.

## Interface
- WIDTH, 16, pixel/data width
- ADDR_W, 13, BRAM byte address width
- TIMEOUT, 20000, watchdog limit in clk cycles for one pass (watchdog build only)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- host_start  in  1  request one deskew pass (level sampled each cycle)
- host_en  in  1  host BRAM access enable
- host_we  in  4  host byte write enables
- host_addr  in  ADDR_W  host BRAM address
- host_wdata  in  WIDTH  host write data
- host_rdata  out  WIDTH  host read data
- busy  out  1  pass in progress; BRAM owned by engine
- done_irq  out  1  one-cycle pulse at end of pass
- status  out  4  [0] last pass ok, [1] collision (sticky), [2] timeout (sticky), [3] reserved 0
- frame_cnt  out  8  completed passes, wraps 255->0
- eng_reset  out  1  engine synchronous active-low reset
- eng_start  out  1  engine start
- eng_ready  in  1  engine idle
- eng_done  in  1  engine done_interrupt
- eng_address  in  ADDR_W  engine address
- eng_out_data  in  WIDTH  engine write data
- eng_en  in  1  engine enable
- eng_we  in  4  engine write enables
- eng_in_data  out  WIDTH  engine read data
- mem_addr  out  ADDR_W  BRAM address
- mem_din  out  WIDTH  BRAM write data
- mem_dout  in  WIDTH  BRAM read data (1-cycle latency)
- mem_en  out  1  BRAM enable
- mem_we  out  4  BRAM byte write enables

## Operation
- States: IDLE, LAUNCH, RUN, DONE, ABORT (ABORT is present only in the watchdog build).
- IDLE: `owner`=host. If `host_start`=1 and `eng_ready`=1, go to LAUNCH and clear `status[1:0]`. A `host_start` with `eng_ready`=0 is ignored.
- LAUNCH: `eng_start`=1 for exactly one cycle. `owner`<=engine. Go to RUN.
- RUN: `busy`=1. If `eng_done`=1, go to DONE.
- DONE: `done_irq`=1, `status[0]`<=1, `frame_cnt`<=`frame_cnt`+1, `owner`<=host, go to IDLE.
- Port mux is combinational on the registered `owner` bit:
  - owner=host: `mem_*`=`host_*`; `eng_in_data`=0.
  - owner=engine: `mem_*`=`eng_*`; `host_rdata`=0.
  - `mem_dout` is routed to both read-data outputs in every cycle, gated by owner.
- Any `host_en`=1 while `busy`=1:
  - The access is dropped; the host never reaches `mem_*`.
  - `status[1]`<=1, sticky until the next accepted start.
- Engine `en`/`we` while owner=host are ignored.
- `eng_reset` = `reset` AND NOT `abort_pulse`.

## Timing
- Reset values:
  - state=IDLE, owner=host, `status`=0, `frame_cnt`=0.
  - `busy`=0, `done_irq`=0, `eng_start`=0, `eng_reset`=0 during reset.
  - All `mem_*` follow the host inputs.
- Start latency: `host_start` at cycle n gives `eng_start` at cycle n+1 and `busy` from cycle n+1 onward.
- Completion: `eng_done` at cycle m gives `done_irq` at m+1. `busy` falls at m+2, and the host owns the port from m+2.
- `host_start` held high through DONE starts a new pass only from IDLE (cycle m+2 or later), and only if `eng_ready`=1.
- `host_start` is ignored while not IDLE.
- Reset mid-pass: return to IDLE on the next edge and assert `eng_reset`. No `done_irq` is issued.

## Configuration
- `DESKEW_CTRL_WATCHDOG_EN` defined:
  - A cycle counter clears in LAUNCH and increments in RUN.
  - If it reaches TIMEOUT with no `eng_done`, go to ABORT.
  - ABORT drives `eng_reset`=0 for one cycle, sets `status[2]`=1 and `status[0]`=0, pulses `done_irq`, sets owner=host, and returns to IDLE.
  - `frame_cnt` does not increment on an abort.
  - `status[2]` clears only on reset.
- `DESKEW_CTRL_WATCHDOG_EN` undefined:
  - No counter and no ABORT state; RUN waits indefinitely.
  - `status[2]` is tied to 0.

## Test plan
- **Load, start, read back:** write 784 pixels through the host port, pulse `host_start` with `eng_ready`=1. Required: `eng_start` for 1 cycle, `busy`=1 until `eng_done`+2, `done_irq` for 1 cycle, `status`=4'b0001, `frame_cnt`=1. Host reads of addresses 784*4 onward return the engine's written values.
- **Port isolation:** during RUN drive `host_en`=1, `host_we`=4'hF, `host_addr`=0, `host_wdata`=16'hBEEF. Required: BRAM word 0 unchanged, `status[1]`=1, `host_rdata`=0. `status[1]` clears on the next accepted start.
- **Start gating:** `host_start` with `eng_ready`=0 gives no `eng_start`. `host_start` held continuously high produces back-to-back passes with exactly 2 idle-owner cycles between `eng_done` and the next `eng_start`.
- **Watchdog (macro on, TIMEOUT=100):** the engine never asserts `eng_done`. Required: at RUN cycle 100, `eng_reset` low for 1 cycle, `done_irq` pulse, `status`=4'b0100, `frame_cnt` unchanged, `busy`=0.
- **Reset mid-pass:** assert `reset`=0 for 1 cycle during RUN. Required: next cycle state IDLE, `busy`=0, `status`=0, `frame_cnt`=0, no `done_irq`.
- **Counter wrap:** complete 256 passes; `frame_cnt` reads 0 after the 256th.
